// File: rtl/uart_pkg.sv
// Shared types and constants for the UART line-echo slice.
// Byte width, FSM encoding and line-control characters.
package uart_pkg;

  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] CR = 8'h0D;
  localparam logic [BYTE_W-1:0] LF = 8'h0A;

  typedef enum logic [2:0] {
    COLLECT,
    LOAD,
    WAIT_RDY,
    SEND,
    WAIT_BUSY,
    WAIT_IDLE
  } state_t;

endpackage

// File: rtl/uart_line_echo_if.sv
// Receiver/transmitter handshake bundle for the line echo.
// slave faces the echo block, master faces the UART side.
interface uart_line_echo_if;

  logic                        rdsig;
  logic [uart_pkg::BYTE_W-1:0] rxdata;
  logic                        idle;
  logic                        wrsig;
  logic [uart_pkg::BYTE_W-1:0] dataout;

  modport slave (
    input  rdsig,
    input  rxdata,
    input  idle,
    output wrsig,
    output dataout
  );

  modport master (
    output rdsig,
    output rxdata,
    output idle,
    input  wrsig,
    input  dataout
  );

endinterface

// File: rtl/byte_fifo.sv
// Circular byte buffer with wrap-bit pointers.
// Writes when full and reads when empty are ignored.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr,
  input  logic              i_rd,
  input  logic [BYTE_W-1:0] i_din,
  output logic [BYTE_W-1:0] o_dout,
  output logic              o_full,
  output logic              o_empty,
  output logic [AW:0]       o_level
);

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wp;
  logic [AW:0]       r_rp;
  logic [AW:0]       r_level;
  logic [AW:0]       w_wp_n;
  logic [AW:0]       w_rp_n;
  logic              w_we;
  logic              w_re;

  assign o_full  = (r_wp[AW] != r_rp[AW]) &&
                   (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign o_empty = (r_wp == r_rp);
  assign w_we    = i_wr & ~o_full;
  assign w_re    = i_rd & ~o_empty;
  assign w_wp_n  = r_wp + {{AW{1'b0}}, w_we};
  assign w_rp_n  = r_rp + {{AW{1'b0}}, w_re};
  assign o_dout  = r_mem[r_rp[AW-1:0]];
  assign o_level = r_level;

  // pointer and occupancy update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      r_wp    <= w_wp_n;
      r_rp    <= w_rp_n;
      r_level <= w_wp_n - w_rp_n;
    end
  end

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wp[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/uart_line_echo.sv
// Line-buffered echo between UART receiver and transmitter.
// Buffers a line, then replays it with optional LF after TERM.
module uart_line_echo
  import uart_pkg::*;
#(
  parameter int                DEPTH        = 16,
  parameter logic [BYTE_W-1:0] TERM         = CR,
  parameter bit                APPEND_LF    = 1'b1,
  parameter int                BUSY_TIMEOUT = 64,
  localparam int               LW = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_line_echo_if.slave    bus,
  output logic [LW-1:0]      fifo_level,
  output logic               overflow,
  output logic               busy
);

  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(BUSY_TIMEOUT - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  state_t            r_state;
  state_t            w_nxt;
  logic              r_rdsig_q;
  logic              r_term_hit;
  logic              r_lf_pend;
  logic [BYTE_W-1:0] r_dataout;
  logic [CW-1:0]     r_cnt;
  logic              r_ovf;

  logic              w_wr;
  logic              w_acc;
  logic              w_full;
  logic              w_empty;
  logic [BYTE_W-1:0] w_head;
  logic              w_pop;
  logic              w_ld_lf;
  logic              w_send;

  assign w_wr  = bus.rdsig & ~r_rdsig_q;
  assign w_acc = w_wr & ~w_full;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr    (w_wr),
    .i_rd    (w_pop),
    .i_din   (bus.rxdata),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  // rdsig edge history, TERM marker and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdsig_q  <= 1'b0;
      r_term_hit <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_rdsig_q  <= bus.rdsig;
      r_term_hit <= w_acc & (bus.rxdata == TERM);
      if (w_wr && w_full) r_ovf <= 1'b1;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= COLLECT;
    else        r_state <= w_nxt;
  end

  // next state and per-cycle controls
  always_comb begin
    w_nxt   = r_state;
    w_pop   = 1'b0;
    w_ld_lf = 1'b0;
    w_send  = 1'b0;
    unique case (r_state)
      COLLECT: begin
        if (r_term_hit || fifo_level == FULL_LVL)
          w_nxt = LOAD;
      end
      LOAD: begin
        if (r_lf_pend) begin
          w_ld_lf = 1'b1;
          w_nxt   = WAIT_RDY;
        end else if (!w_empty) begin
          w_pop = 1'b1;
          w_nxt = WAIT_RDY;
        end else begin
          w_nxt = COLLECT;
        end
      end
      WAIT_RDY: begin
        if (bus.idle) w_nxt = SEND;
      end
      SEND: begin
        w_send = 1'b1;
        w_nxt  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!bus.idle || r_cnt == LAST)
          w_nxt = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (bus.idle) w_nxt = LOAD;
      end
      default: w_nxt = COLLECT;
    endcase
  end

  // output byte, pending LF and busy-wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dataout <= '0;
      r_lf_pend <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (w_ld_lf) begin
        r_dataout <= LF;
        r_lf_pend <= 1'b0;
      end else if (w_pop) begin
        r_dataout <= w_head;
        if (APPEND_LF && w_head == TERM)
          r_lf_pend <= 1'b1;
      end
      if (w_send)
        r_cnt <= '0;
      else if (r_state == WAIT_BUSY)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.wrsig   = (r_state == SEND);
  assign bus.dataout = r_dataout;
  assign overflow    = r_ovf;
  assign busy        = (r_state != COLLECT);

endmodule
